uart_tx_fifo_param: RTL
=======================

// Module: uart_tx_fifo_param
// PURPOSE
//  Parametrised UART transmitter. Configurable baud, data width, parity and stop bits.
//  Fronted by a small FIFO with a valid/ready write handshake, so a host can queue words.
//  Sits between on-chip logic and the serial TX pin. Frames leave back-to-back while queued.
// PARAMETERS
//  CLK_FREQ     50_000_000  system clock, Hz
//  BAUD         115200      line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer, 434 at defaults)
//  DATA_BITS    8           data bits per frame, legal 5..9, sent LSB first
//  PARITY_MODE  0           0 none, 1 odd, 2 even
//  STOP_BITS    1           1 or 2
//  FIFO_DEPTH   4           queue depth, power of 2, >=2
// PORTS
//  clk          in   1                 system clock, rising edge
//  uart_rst_n   in   1                 asynchronous, active-low reset
//  tx_valid     in   1                 host presents a word
//  tx_data      in   DATA_BITS         word to send, sampled on accept
//  tx_ready     out  1                 FIFO can accept (= !full)
//  txd          out  1                 serial line, idle high, registered
//  tx_busy      out  1                 frame in progress or FIFO non-empty
//  fifo_level   out  clog2(DEPTH)+1    words queued, excluding the frame on the wire
// BEHAVIOUR
//  Reset (async assert, sync release): txd=1, tx_ready=1, tx_busy=0, fifo_level=0.
//   FIFO pointers cleared and FSM forced to IDLE, including mid-frame; txd goes high immediately.
//  Accept: tx_valid && tx_ready at a rising edge pushes tx_data. tx_data is don't-care otherwise.
//   Later changes to tx_data do not affect queued words.
//  tx_ready depends only on full, never on a same-cycle pop. A push into a full FIFO is impossible.
//  FSM states and transitions:
//   IDLE -> START when FIFO is non-empty; pop and load shift register on that edge.
//   START -> DATA -> PARITY (only if PARITY_MODE!=0) -> STOP -> STOP2 (only if STOP_BITS==2).
//  txd per state: START drives 0. DATA drives shift[0], shifting right each bit, DATA_BITS bits.
//   PARITY drives ^data for even, ~^data for odd. STOP/STOP2 drive 1.
//  Each bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that runs 0..CLKS_PER_BIT-1.
//   The counter restarts at every state change and holds at 0 in IDLE.
//  Latency: a word pushed into an empty FIFO with the FSM in IDLE at edge N is popped at edge N+1.
//   txd is low from edge N+1.
//  Back-to-back: at the end of the last stop bit, a non-empty FIFO sends the FSM directly to START.
//   No idle cycle is inserted. An empty FIFO sends it to IDLE.
//  Simultaneous push and pop: level unchanged, both occur. Push to an empty FIFO is not
//   poppable in the same cycle.
//  Pointers wrap modulo FIFO_DEPTH. full/empty use an extra pointer bit.
//  Frame length = (1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
// STRUCTURE
//  Shared header uart_defs.vh: FSM state encodings, PARITY_NONE/ODD/EVEN constants,
//   clog2 function. The future uart_rx successor uses the same header.
//  Sub-module uart_sync_fifo (DATA_BITS wide, FIFO_DEPTH deep). Ports: push, pop, full,
//   empty, level, async reset. Top holds the FSM, baud counter, bit counter and shift register.
// TESTING (CLK_FREQ=1_000_000, BAUD=100_000 -> 10 clk/bit unless noted)
//  1 Defaults, push 0x5B -> txd falls 1 cycle after accept.
//    Bits 0,1,1,0,1,1,0,1,0,1 at 10 clk each; tx_busy is 0 after 100 cycles.
//  2 PARITY_MODE=2, push 0x5B -> parity bit 1. PARITY_MODE=1 -> parity bit 0.
//    Frame is 110 cycles in both cases.
//  3 Hold tx_valid for 6 words 0x01..0x06 -> 5 accepted: 1 on wire + 4 queued, then tx_ready=0.
//    The remaining word is accepted after the first frame pops. All 6 frames arrive gapless
//    and in order, 600 cycles.
//  4 Assert uart_rst_n=0 mid-DATA of frame 2 with 3 queued -> txd=1 immediately, fifo_level=0,
//    tx_ready=1. No further frames after release.
//  5 STOP_BITS=2, DATA_BITS=7, push 0x7F -> frame is 100 cycles (1+7+2 bits)
//    with stop high for 20 cycles.
//  6 Defaults at 50 MHz/115200, push 0xA5 -> each bit exactly 434 cycles, frame 4340 cycles.

Source files
------------

// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared UART definitions: transmitter FSM encoding, parity modes and a clog2 helper.
// Intended to be reused unchanged by the matching receiver.
package uart_tx_fifo_param_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
// Read data is the head word, available combinationally while not empty.
module uart_sync_fifo
  import uart_tx_fifo_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level    = wr_ptr_q - rd_ptr_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter fed by a small FIFO; frames leave back-to-back while
// words are queued. txd is registered and idles high.
module uart_tx_fifo_param
  import uart_tx_fifo_param_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       uart_rst_n,
  input  logic                       tx_valid,
  input  logic [DATA_BITS-1:0]       tx_data,
  output logic                       tx_ready,
  output logic                       txd,
  output logic                       tx_busy,
  output logic [clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = clog2(CLKS_PER_BIT);
  localparam int BW = clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = 1;

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 bit_end, last_stop;

  assign tx_ready = !fifo_full;

  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (uart_rst_n),
    .push     (tx_valid && tx_ready),
    .push_data(tx_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign bit_end   = (cnt_q == CNT_LAST);
  assign last_stop = bit_end && ((state_q == S_STOP && STOP_BITS == 1) || state_q == S_STOP2);
  // Popping at the end of the last stop bit is what makes queued frames gapless.
  assign fifo_pop  = !fifo_empty && (state_q == S_IDLE || last_stop);

  function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
    return (PARITY_MODE == PARITY_ODD) ? ~^data : ^data;
  endfunction

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    cnt_d   = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + CNT_ONE;
    case (state_q)
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (bit_q == BIT_LAST) state_d = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
        else                   bit_d   = bit_q + BIT_ONE;
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = (STOP_BITS == 2) ? S_STOP2 : S_IDLE;
      S_STOP2:  if (bit_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (fifo_pop) begin
      state_d = S_START;
      shift_d = fifo_data;
      par_d   = parity_of(fifo_data);
    end
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (state_q != S_IDLE) || !fifo_empty;

endmodule
